sort_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that lets N_CH Avalon-ST requesters share one main_sort instance.
- Grants one requester at a time and forwards its whole packet into the sorter sink.
- Records the granted channel id in a small FIFO.
- Routes each sorted output packet back to the src port of the requester that sent it.

---
 rtl/sort_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_sort_rr_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_rr_arbiter.sv
// sort_rr_arbiter: packet round-robin front end sharing one main_sort
// among N_CH Avalon-ST requesters; results are routed back by channel id.
// Ports: clk_i/arst_i clock and async reset; snk_* per-channel requester
// sinks; sort_snk_* to the sorter sink; sort_src_* from the sorter
// source; src_* per-channel result sources (lane k = channel k).
module sort_rr_arbiter #(
  parameter  int DWIDTH        = 8,
  parameter  int N_CH          = 4,
  parameter  int ID_FIFO_DEPTH = 4,
  localparam int CH_W          = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [N_CH*DWIDTH-1:0] snk_data_i,
  input  logic [N_CH-1:0]        snk_startofpacket_i,
  input  logic [N_CH-1:0]        snk_endofpacket_i,
  input  logic [N_CH-1:0]        snk_valid_i,
  output logic [N_CH-1:0]        snk_ready_o,
  output logic [DWIDTH-1:0]      sort_snk_data_o,
  output logic                   sort_snk_startofpacket_o,
  output logic                   sort_snk_endofpacket_o,
  output logic                   sort_snk_valid_o,
  input  logic                   sort_snk_ready_i,
  input  logic [DWIDTH-1:0]      sort_src_data_i,
  input  logic                   sort_src_startofpacket_i,
  input  logic                   sort_src_endofpacket_i,
  input  logic                   sort_src_valid_i,
  output logic                   sort_src_ready_o,
  output logic [N_CH*DWIDTH-1:0] src_data_o,
  output logic [N_CH-1:0]        src_startofpacket_o,
  output logic [N_CH-1:0]        src_endofpacket_o,
  output logic [N_CH-1:0]        src_valid_o,
  input  logic [N_CH-1:0]        src_ready_i
);

  localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ARB, XFER} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   grant, last_grant, pick, head;
  logic [CH_W-1:0]   idx;
  logic [N_CH-1:0]   elig;
  logic              found, push, pop, full, hv, eop_acc;
  logic [CH_W-1:0]   mem [ID_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;

  assign elig    = snk_valid_i & snk_startofpacket_i;
  assign full    = (cnt == CNT_W'(ID_FIFO_DEPTH));
  assign hv      = (cnt != '0);
  assign head    = mem[rd_ptr];
  assign push    = (state == ARB) && found && !full;
  assign eop_acc = sort_snk_valid_o && sort_snk_ready_i
                   && sort_snk_endofpacket_o;
  assign pop     = sort_src_valid_i && sort_src_ready_o
                   && sort_src_endofpacket_i;

  // Scan last_grant+1, +2, ... wrapping at N_CH; first SOP-valid wins.
  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    pick  = last_grant;
    for (int i = 1; i <= N_CH; i++) begin
      j = int'(last_grant) + i;
      if (j >= N_CH) j = j - N_CH;
      idx = CH_W'(j);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= ARB;
      grant      <= '0;
      last_grant <= CH_W'(N_CH - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (push) grant <= pick;
      if (state == XFER && eop_acc) last_grant <= grant;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= pick;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:     if (push) state_nxt = XFER;
      XFER:    if (eop_acc) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Sink side: granted channel is wired straight through during XFER.
  always_comb begin
    snk_ready_o              = '0;
    sort_snk_data_o          = '0;
    sort_snk_startofpacket_o = 1'b0;
    sort_snk_endofpacket_o   = 1'b0;
    sort_snk_valid_o         = 1'b0;
    if (state == XFER) begin
      for (int k = 0; k < N_CH; k++) begin
        if (grant == CH_W'(k)) begin
          sort_snk_data_o          = snk_data_i[k*DWIDTH +: DWIDTH];
          sort_snk_startofpacket_o = snk_startofpacket_i[k];
          sort_snk_endofpacket_o   = snk_endofpacket_i[k];
          sort_snk_valid_o         = snk_valid_i[k];
          snk_ready_o[k]           = sort_snk_ready_i;
        end
      end
    end
  end

  // Source side: results go to the lane named by the oldest recorded id;
  // with no id recorded the sorter output is held off, never dropped.
  always_comb begin
    src_data_o          = '0;
    src_startofpacket_o = '0;
    src_endofpacket_o   = '0;
    src_valid_o         = '0;
    sort_src_ready_o    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (hv && head == CH_W'(k)) begin
        src_data_o[k*DWIDTH +: DWIDTH] = sort_src_data_i;
        src_startofpacket_o[k]         = sort_src_startofpacket_i;
        src_endofpacket_o[k]           = sort_src_endofpacket_i;
        src_valid_o[k]                 = sort_src_valid_i;
        sort_src_ready_o               = src_ready_i[k];
      end
    end
  end

endmodule

// File: tb/tb_sort_rr_arbiter.sv
// Bench for sort_rr_arbiter: behavioural sorter stand-in plus a per-lane
// scoreboard of sorted packets and a packet-order check.
module tb_sort_rr_arbiter;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic arst;
  logic [NC*DW-1:0] snk_data;
  logic [NC-1:0] snk_sop, snk_eop, snk_valid, snk_ready;
  logic [DW-1:0] ss_data;
  logic ss_sop, ss_eop, ss_valid, ss_ready;
  logic [DW-1:0] sr_data;
  logic sr_sop, sr_eop, sr_valid, sr_ready;
  logic [NC*DW-1:0] src_data;
  logic [NC-1:0] src_sop, src_eop, src_valid, src_ready;

  sort_rr_arbiter #(
    .DWIDTH(DW), .N_CH(NC), .ID_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .arst_i(arst),
    .snk_data_i(snk_data),
    .snk_startofpacket_i(snk_sop),
    .snk_endofpacket_i(snk_eop),
    .snk_valid_i(snk_valid),
    .snk_ready_o(snk_ready),
    .sort_snk_data_o(ss_data),
    .sort_snk_startofpacket_o(ss_sop),
    .sort_snk_endofpacket_o(ss_eop),
    .sort_snk_valid_o(ss_valid),
    .sort_snk_ready_i(ss_ready),
    .sort_src_data_i(sr_data),
    .sort_src_startofpacket_i(sr_sop),
    .sort_src_endofpacket_i(sr_eop),
    .sort_src_valid_i(sr_valid),
    .sort_src_ready_o(sr_ready),
    .src_data_o(src_data),
    .src_startofpacket_o(src_sop),
    .src_endofpacket_o(src_eop),
    .src_valid_o(src_valid),
    .src_ready_i(src_ready)
  );

  always #5 clk = ~clk;

  // Entries are {sop, eop, data}.
  logic [DW+1:0] tx_q [NC][$];
  logic [DW+1:0] exp_q [NC][$];
  logic [DW+1:0] so_q [$];
  int cur [$];
  int sbuf [$];
  int pbuf [$];
  int out_order [$];
  int want_order [$];
  int vpct [NC];
  int rpct [NC];
  int kpct = 100;
  logic [NC-1:0] hold = '0;
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Requester drivers and result-side ready.
  initial begin
    logic [NC-1:0] sfire;
    snk_valid = '0;
    snk_sop = '0;
    snk_eop = '0;
    snk_data = '0;
    src_ready = '0;
    forever begin
      @(negedge clk);
      sfire = snk_valid & snk_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NC; k++) begin
        if (sfire[k] && tx_q[k].size() > 0) void'(tx_q[k].pop_front());
        if (tx_q[k].size() > 0 && $urandom_range(1, 100) <= vpct[k]) begin
          snk_valid[k] = 1'b1;
          {snk_sop[k], snk_eop[k], snk_data[k*DW +: DW]} = tx_q[k][0];
        end else begin
          snk_valid[k] = 1'b0;
          snk_sop[k] = 1'b0;
          snk_eop[k] = 1'b0;
          snk_data[k*DW +: DW] = '0;
        end
        src_ready[k] = !hold[k] && ($urandom_range(1, 100) <= rpct[k]);
      end
    end
  end

  // Stand-in for main_sort: whole packet in, ascending packet out, FIFO order.
  initial begin
    logic kfire, keop, rfire;
    logic [DW-1:0] kdata;
    int t;
    ss_ready = 1'b0;
    sr_valid = 1'b0;
    sr_sop = 1'b0;
    sr_eop = 1'b0;
    sr_data = '0;
    forever begin
      @(negedge clk);
      kfire = ss_valid & ss_ready;
      kdata = ss_data;
      keop = ss_eop;
      rfire = sr_valid & sr_ready;
      @(posedge clk);
      #1;
      if (arst) begin
        cur.delete();
        so_q.delete();
      end else begin
        if (rfire && so_q.size() > 0) void'(so_q.pop_front());
        if (kfire) begin
          cur.push_back(int'(kdata));
          if (keop) begin
            sbuf = cur;
            for (int i = 0; i < sbuf.size(); i++)
              for (int j = 0; j + 1 < sbuf.size() - i; j++)
                if (sbuf[j] > sbuf[j+1]) begin
                  t = sbuf[j];
                  sbuf[j] = sbuf[j+1];
                  sbuf[j+1] = t;
                end
            for (int i = 0; i < sbuf.size(); i++)
              so_q.push_back({i == 0, i == sbuf.size() - 1, DW'(sbuf[i])});
            cur.delete();
          end
        end
      end
      ss_ready = ($urandom_range(1, 100) <= kpct);
      if (so_q.size() > 0) begin
        sr_valid = 1'b1;
        {sr_sop, sr_eop, sr_data} = so_q[0];
      end else begin
        sr_valid = 1'b0;
        sr_sop = 1'b0;
        sr_eop = 1'b0;
        sr_data = '0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!arst) begin
      for (int k = 0; k < NC; k++) begin
        if (src_valid[k]) begin
          if (exp_q[k].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_valid lane %0d: got valid 1 want 0", k);
          end else if (src_ready[k]) begin
            check($sformatf("lane%0d_beat", k),
                  {22'b0, src_sop[k], src_eop[k], src_data[k*DW +: DW]},
                  {22'b0, exp_q[k][0]});
            if (src_sop[k]) out_order.push_back(k);
            void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic push_tx(input int ch);
    for (int i = 0; i < pbuf.size(); i++)
      tx_q[ch].push_back({i == 0, i == pbuf.size() - 1, DW'(pbuf[i])});
  endtask

  // Expected result by counting each value in ascending order.
  task automatic push_exp(input int ch);
    int n;
    n = 0;
    for (int v = 0; v < 256; v++)
      for (int i = 0; i < pbuf.size(); i++)
        if (pbuf[i] == v) begin
          exp_q[ch].push_back({n == 0, n == pbuf.size() - 1, DW'(v)});
          n++;
        end
  endtask

  task automatic queue_pkt(input int ch, input int len);
    pbuf.delete();
    for (int i = 0; i < len; i++) pbuf.push_back(int'($urandom_range(0, 255)));
    push_tx(ch);
    push_exp(ch);
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < NC; k++)
      if (tx_q[k].size() != 0 || exp_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      @(posedge clk);
      #2;
      c++;
      done = all_empty();
    end
    check({name, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic check_order(input string name);
    check({name, "_npkts"}, out_order.size(), want_order.size());
    for (int i = 0; i < want_order.size() && i < out_order.size(); i++)
      check($sformatf("%s_pkt%0d_lane", name, i), out_order[i], want_order[i]);
  endtask

  task automatic set_pct(input int v, input int r, input int s);
    for (int k = 0; k < NC; k++) begin
      vpct[k] = v;
      rpct[k] = r;
    end
    kpct = s;
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    check({name, "_snk_ready"}, 32'(snk_ready), 32'd0);
    check({name, "_src_valid"}, 32'(src_valid), 32'd0);
    for (int k = 0; k < NC; k++) begin
      tx_q[k].delete();
      exp_q[k].delete();
    end
    out_order.delete();
    repeat (3) @(posedge clk);
    #2;
    arst = 1'b0;
  endtask

  initial begin
    int c;
    arst = 1'b1;
    set_pct(100, 100, 100);
    repeat (3) @(posedge clk);
    #2;
    check("rst_snk_ready", 32'(snk_ready), 32'd0);
    check("rst_sort_snk_valid", 32'(ss_valid), 32'd0);
    check("rst_sort_snk_sop_eop", 32'({ss_sop, ss_eop}), 32'd0);
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_src_sop_eop", 32'({src_sop, src_eop}), 32'd0);
    check("rst_sort_src_ready", 32'(sr_ready), 32'd0);
    arst = 1'b0;

    // Single channel, fixed packet.
    pbuf.delete();
    pbuf.push_back(9);
    pbuf.push_back(3);
    pbuf.push_back(7);
    pbuf.push_back(1);
    pbuf.push_back(5);
    push_tx(2);
    exp_q[2].push_back({1'b1, 1'b0, 8'd1});
    exp_q[2].push_back({1'b0, 1'b0, 8'd3});
    exp_q[2].push_back({1'b0, 1'b0, 8'd5});
    exp_q[2].push_back({1'b0, 1'b0, 8'd7});
    exp_q[2].push_back({1'b0, 1'b1, 8'd9});
    out_order.delete();
    wait_drain(500, "t1");
    want_order.delete();
    want_order.push_back(2);
    check_order("t1");

    // All four request together after reset.
    do_reset("t2rst");
    for (int k = 0; k < NC; k++) queue_pkt(k, int'($urandom_range(2, 16)));
    wait_drain(2000, "t2");
    want_order.delete();
    for (int k = 0; k < NC; k++) want_order.push_back(k);
    check_order("t2");

    // Fairness: ch3 arrives during ch1's first of two packets.
    out_order.delete();
    queue_pkt(1, 8);
    queue_pkt(1, 8);
    c = 0;
    while (c < 200 && tx_q[1].size() >= 16) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("t3_ch1_started", 32'(tx_q[1].size() < 16), 32'd1);
    queue_pkt(3, 5);
    wait_drain(2000, "t3");
    want_order.delete();
    want_order.push_back(1);
    want_order.push_back(3);
    want_order.push_back(1);
    check_order("t3");

    // Result backpressure on lane 0 with lane 1 queued behind it.
    out_order.delete();
    hold[0] = 1'b1;
    queue_pkt(0, 6);
    queue_pkt(1, 6);
    c = 0;
    while (c < 300 && !src_valid[0]) begin
      @(negedge clk);
      c++;
    end
    check("t4_lane0_valid", 32'(src_valid[0]), 32'd1);
    repeat (20) begin
      @(negedge clk);
      check("t4_sort_src_ready_held", 32'(sr_ready), 32'd0);
    end
    @(posedge clk);
    #2;
    hold[0] = 1'b0;
    wait_drain(2000, "t4");
    want_order.delete();
    want_order.push_back(0);
    want_order.push_back(1);
    check_order("t4");

    // Random traffic, gaps and backpressure.
    for (int k = 0; k < NC; k++) begin
      vpct[k] = int'($urandom_range(25, 100));
      rpct[k] = int'($urandom_range(30, 100));
    end
    kpct = int'($urandom_range(50, 100));
    for (int p = 0; p < 200; p++)
      queue_pkt(int'($urandom_range(0, NC - 1)), int'($urandom_range(2, 16)));
    wait_drain(40000, "t5");

    // Reset in the middle of a packet, then fresh traffic.
    set_pct(100, 100, 100);
    queue_pkt(3, 16);
    c = 0;
    while (c < 200 && !(tx_q[3].size() > 0 && tx_q[3].size() < 12)) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("t6_midxfer_ready", 32'(snk_ready), 32'h8);
    do_reset("t6rst");
    queue_pkt(1, int'($urandom_range(2, 16)));
    queue_pkt(0, int'($urandom_range(2, 16)));
    wait_drain(2000, "t6");
    want_order.delete();
    want_order.push_back(0);
    want_order.push_back(1);
    check_order("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
